// File: rtl/fetch_pipe_ctrl_if.sv
// Fetch-stage control bundle: stall/redirect/prediction inputs toward the PC
// sequencer and fetch address plus pipeline-register controls back out.
interface fetch_pipe_ctrl_if;
  logic        MEM_STALL;
  logic        ID_STALL;
  logic        MISPREDICT;
  logic [31:0] MISPREDICT_TARGET;
  logic        PRED_TAKEN;
  logic [31:0] PRED_TARGET;
  logic [31:0] PC_OUT;
  logic        FETCH_VALID;
  logic        IF_ID_STALL;
  logic        IF_ID_FLUSH;
  logic        ID_EX_FLUSH;
  logic [15:0] REDIRECT_COUNT;
  logic [15:0] STALL_COUNT;

  modport master (
    output MEM_STALL,
    output ID_STALL,
    output MISPREDICT,
    output MISPREDICT_TARGET,
    output PRED_TAKEN,
    output PRED_TARGET,
    input  PC_OUT,
    input  FETCH_VALID,
    input  IF_ID_STALL,
    input  IF_ID_FLUSH,
    input  ID_EX_FLUSH,
    input  REDIRECT_COUNT,
    input  STALL_COUNT
  );

  modport slave (
    input  MEM_STALL,
    input  ID_STALL,
    input  MISPREDICT,
    input  MISPREDICT_TARGET,
    input  PRED_TAKEN,
    input  PRED_TARGET,
    output PC_OUT,
    output FETCH_VALID,
    output IF_ID_STALL,
    output IF_ID_FLUSH,
    output ID_EX_FLUSH,
    output REDIRECT_COUNT,
    output STALL_COUNT
  );
endinterface

// File: rtl/fetch_pipe_ctrl.sv
// Fetch-stage sequencer: owns the PC, arbitrates redirect/stall/prediction
// sources, drives IF/ID and ID/EX stall/flush, and keeps debug counters.
module fetch_pipe_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          REFILL_CYCLES = 2
) (
  input logic              CLK,
  input logic              RESET,
  fetch_pipe_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_RUN,
    S_HOLD,
    S_WAIT_REDIRECT,
    S_FLUSH,
    S_REFILL
  } state_e;

  // The FLUSH cycle is itself the first refill cycle, so REFILL after a
  // redirect runs one cycle shorter than REFILL out of reset.
  localparam logic [2:0] CNT_RESET = 3'(REFILL_CYCLES - 1);
  localparam logic [2:0] CNT_FLUSH = 3'((REFILL_CYCLES > 1) ? (REFILL_CYCLES - 2) : 0);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [2:0]  refill_cnt_q, refill_cnt_d;
  logic        flush_q, flush_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        stall_any;
  logic [31:0] run_pc;

  assign stall_any = bus.MEM_STALL | bus.ID_STALL;
  assign run_pc    = bus.PRED_TAKEN ? bus.PRED_TARGET : (pc_q + 32'd4);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_REFILL;
      pc_q           <= RESET_PC;
      pend_q         <= '0;
      refill_cnt_q   <= CNT_RESET;
      flush_q        <= 1'b1;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pend_q         <= pend_d;
      refill_cnt_q   <= refill_cnt_d;
      flush_q        <= flush_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    refill_cnt_d = refill_cnt_q;

    unique case (state_q)
      S_RUN, S_HOLD: begin
        if (bus.MISPREDICT) begin
          if (!bus.MEM_STALL) begin
            pc_d    = bus.MISPREDICT_TARGET;
            state_d = S_FLUSH;
          end else begin
            pend_d  = bus.MISPREDICT_TARGET;
            state_d = S_WAIT_REDIRECT;
          end
        end else if (stall_any) begin
          state_d = S_HOLD;
        end else begin
          pc_d    = run_pc;
          state_d = S_RUN;
        end
      end

      S_WAIT_REDIRECT: begin
        // A pulse coinciding with the stall release is the newest target.
        if (bus.MISPREDICT) begin
          pend_d = bus.MISPREDICT_TARGET;
        end
        if (!bus.MEM_STALL) begin
          pc_d    = bus.MISPREDICT ? bus.MISPREDICT_TARGET : pend_q;
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (!bus.MEM_STALL) begin
          pc_d = run_pc;
        end
        if (REFILL_CYCLES <= 1) begin
          state_d = S_RUN;
        end else begin
          refill_cnt_d = CNT_FLUSH;
          state_d      = S_REFILL;
        end
      end

      S_REFILL: begin
        if (bus.MISPREDICT) begin
          if (!bus.MEM_STALL) begin
            pc_d    = bus.MISPREDICT_TARGET;
            state_d = S_FLUSH;
          end else begin
            pend_d  = bus.MISPREDICT_TARGET;
            state_d = S_WAIT_REDIRECT;
          end
        end else if (!stall_any) begin
          pc_d = run_pc;
          if (refill_cnt_q == '0) begin
            state_d = S_RUN;
          end else begin
            refill_cnt_d = refill_cnt_q - 3'd1;
          end
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_comb begin
    flush_d        = (state_d == S_FLUSH);
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if ((state_q == S_FLUSH) && (redirect_cnt_q != '1)) begin
      redirect_cnt_d = redirect_cnt_q + 16'd1;
    end
    if (((state_q == S_HOLD) || (state_q == S_WAIT_REDIRECT)) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_comb begin
    bus.IF_ID_STALL = 1'b0;
    unique case (state_q)
      S_RUN, S_HOLD, S_REFILL: bus.IF_ID_STALL = stall_any;
      S_WAIT_REDIRECT:         bus.IF_ID_STALL = 1'b1;
      default:                 bus.IF_ID_STALL = 1'b0;
    endcase
  end

  assign bus.PC_OUT         = pc_q;
  assign bus.FETCH_VALID    = (state_q == S_RUN) || (state_q == S_HOLD);
  assign bus.IF_ID_FLUSH    = flush_q;
  assign bus.ID_EX_FLUSH    = flush_q;
  assign bus.REDIRECT_COUNT = redirect_cnt_q;
  assign bus.STALL_COUNT    = stall_cnt_q;

endmodule
